multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multicycle sequencer for the micro ARM core. It replaces per-instruction single-cycle decoding with a Moore FSM that steps a shared-memory datapath through fetch, decode, execute, memory and writeback. The datapath holds one ALU, one memory port, the IR, ALUOut and Data registers. The block owns the architectural NZCV flag register and performs the condition check at decode. It sits between the latched instruction fields (IR) and the datapath mux and enable controls.

Parameters:
PC_REG, 15, register index that redirects writeback to PC
UNUSED_LATCH, 0, reserved; must stay 0

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cond  in  4  IR[31:28]
op  in  2  IR[27:26]; 00 DP, 01 MEM, 10 B, 11 illegal
funct  in  6  IR[25:20]; [5]=I, [0]=S (DP) or L (MEM)
rd  in  4  IR[15:12]
alu_flags  in  4  {N,Z,C,V} from ALU this cycle
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access active
mem_we  out  1  memory write strobe
adr_src  out  1  0 = PC, 1 = ALUOut
ir_we  out  1  IR load
pc_we  out  1  PC load from result bus
reg_we  out  1  register file write
alu_src_a  out  1  0 = RegA, 1 = PC
alu_src_b  out  2  00 RegB, 01 ExtImm, 10 constant 4
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
alu_ctrl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
imm_src  out  2  equals op
reg_src  out  2  {op==MEM & L==0, op==B}; combinational
flags  out  4  registered NZCV
instr_done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse in DECODE for op==11

Behaviour:
- Clock and reset: clk, asynchronous active-low rst_n.
- Reset values:
  - state = FETCH; flags = 0000.
  - While rst_n is low, every write enable and pulse is forced to 0: pc_we, ir_we, reg_we, mem_we, instr_done, illegal.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, alu_ctrl=ADD, result_src=10.
  - ir_we and pc_we equal mem_ready.
  - Holds in FETCH while mem_ready=0; moves to DECODE on mem_ready=1.
- DECODE:
  - Drives alu_src_a=1, alu_src_b=10, ADD (PC+8 onto the read path).
  - cond_ok is evaluated from the registered flags. Encodings EQ..LE follow the ARM table; 1110 = AL; 1111 evaluates as false.
  - If !cond_ok or op==11: go to FETCH and pulse instr_done (illegal also pulses when op==11).
  - Otherwise: MEM goes to MEMADR; DP goes to EXECI if funct[5] is set, else EXECR; B goes to BRANCH.
- MEMADR:
  - Drives alu_src_a=0, alu_src_b=01, ADD.
  - Goes to MEMREAD if L=1, else MEMWRITE.
- MEMREAD:
  - Drives mem_req=1, adr_src=1.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB:
  - Drives result_src=01.
  - If rd==PC_REG, pc_we=1 and reg_we=0; otherwise reg_we=1.
  - Pulses instr_done and goes to FETCH.
- MEMWRITE:
  - Drives mem_req=1, adr_src=1, mem_we=1.
  - Holds until mem_ready; on the ready cycle pulses instr_done and goes to FETCH.
- EXECR and EXECI:
  - Drive alu_src_a=0; alu_src_b=00 in EXECR, 01 in EXECI.
  - alu_ctrl decodes funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, any other ADD.
  - Flag update happens at the clock edge ending this state, only when S=1:
    - ADD or SUB write NZCV from alu_flags.
    - AND or ORR write NZ only; C and V are held.
    - Undecoded funct writes nothing.
  - Both states go to ALUWB.
- ALUWB:
  - Drives result_src=00.
  - If rd==PC_REG, pc_we=1; otherwise reg_we=1.
  - Pulses instr_done and goes to FETCH.
- BRANCH:
  - Drives alu_src_a=0 (RegA carries PC+8), alu_src_b=01, ADD, result_src=10, pc_we=1.
  - Pulses instr_done and goes to FETCH.
- Any unused encoding of the state register goes to FETCH.
- Latency with zero wait states: B 3 cycles, DP 4, STR 4, LDR 5, condition-failed 2. Each memory wait cycle adds 1.
- Fields cond, op, funct and rd are sampled only outside FETCH; the IR holds them stable.
- Reset mid-operation aborts the current instruction immediately. There is no partial write, because the enables are gated during reset.

Decomposition:
- inst.vh gains: the state encoding, the ALU_SRC_A/B constants, the RESULT_SRC constants, and the cond mnemonics.
- It already holds: OP_CODE_*, FUNCT_*, ALU_*_CODE and FLAGW_*.
- One combinational sub-module, cond_check (cond, flags → cond_ok), is instantiated inside multicycle_ctrl.

Test Plan:
- Reset, then ADDS r1 (cond=1110, op=00, funct=001001, rd=1), alu_flags=0110, mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; reg_we in cycle 4; flags=0110; instr_done at cycle 4.
- LDR with rd=15 and 2 wait cycles in FETCH and MEMREAD → total 9 cycles; pc_we only on the FETCH ready cycle and in MEMWB; reg_we never asserted.
- With flags Z=0, run BEQ (cond=0000, op=10) → DECODE returns to FETCH; instr_done in cycle 2; no pc_we in DECODE.
- ANDS with alu_flags=1011 after flags=0011 → flags=1011 (NZ updated, C and V held). Then ORR with S=0 → flags unchanged.
- Two cases on a clean reset: op=11 → illegal pulse in DECODE, then FETCH. cond=1111 on STR → treated as no-op, mem_we never asserted.
- Assert rst_n low during MEMWRITE with mem_ready=0 → mem_we drops immediately; state=FETCH after release; flags=0000.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle sequencer: state codes, datapath mux selects,
// ALU commands, condition mnemonics and the data-processing command decoder.
package multicycle_ctrl_pkg;

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecR    = 4'd6;
    localparam logic [3:0] StExecI    = 4'd7;
    localparam logic [3:0] StAluWb    = 4'd8;
    localparam logic [3:0] StBranch   = 4'd9;

    localparam logic [1:0] OpDp      = 2'b00;
    localparam logic [1:0] OpMem     = 2'b01;
    localparam logic [1:0] OpBranch  = 2'b10;
    localparam logic [1:0] OpIllegal = 2'b11;

    localparam logic       AluSrcAReg  = 1'b0;
    localparam logic       AluSrcAPc   = 1'b1;
    localparam logic [1:0] AluSrcBReg  = 2'b00;
    localparam logic [1:0] AluSrcBImm  = 2'b01;
    localparam logic [1:0] AluSrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOrr = 2'b11;

    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdOrr = 4'b1100;

    localparam logic [1:0] FlagWNone = 2'b00;
    localparam logic [1:0] FlagWNz   = 2'b01;
    localparam logic [1:0] FlagWAll  = 2'b11;

    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondVs = 4'b0110;
    localparam logic [3:0] CondVc = 4'b0111;
    localparam logic [3:0] CondHi = 4'b1000;
    localparam logic [3:0] CondLs = 4'b1001;
    localparam logic [3:0] CondGe = 4'b1010;
    localparam logic [3:0] CondLt = 4'b1011;
    localparam logic [3:0] CondGt = 4'b1100;
    localparam logic [3:0] CondLe = 4'b1101;
    localparam logic [3:0] CondAl = 4'b1110;
    localparam logic [3:0] CondNv = 4'b1111;

    typedef struct packed {
        logic [1:0] alu_ctrl;
        logic [1:0] flag_w;
    } alu_dec_t;

    // Undecoded commands still run the ALU as ADD but never touch the flags.
    function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
        alu_dec_t d;
        case (cmd)
            CmdAdd:  d = '{alu_ctrl: AluAdd, flag_w: FlagWAll};
            CmdSub:  d = '{alu_ctrl: AluSub, flag_w: FlagWAll};
            CmdAnd:  d = '{alu_ctrl: AluAnd, flag_w: FlagWNz};
            CmdOrr:  d = '{alu_ctrl: AluOrr, flag_w: FlagWNz};
            default: d = '{alu_ctrl: AluAdd, flag_w: FlagWNone};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// ARM condition-code evaluation against the registered NZCV flags.
module multicycle_ctrl_cond_check
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ok
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            CondEq: cond_ok = z;
            CondNe: cond_ok = ~z;
            CondCs: cond_ok = c;
            CondCc: cond_ok = ~c;
            CondMi: cond_ok = n;
            CondPl: cond_ok = ~n;
            CondVs: cond_ok = v;
            CondVc: cond_ok = ~v;
            CondHi: cond_ok = c & ~z;
            CondLs: cond_ok = ~c | z;
            CondGe: cond_ok = (n == v);
            CondLt: cond_ok = (n != v);
            CondGt: cond_ok = ~z & (n == v);
            CondLe: cond_ok = z | (n != v);
            CondAl: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the shared-memory datapath through fetch/decode/execute/memory/writeback;
// owns the NZCV flag register.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [3:0]  PC_REG       = 4'd15,
    parameter int unsigned UNUSED_LATCH = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_ctrl,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [3:0] flags,
    output logic       instr_done,
    output logic       illegal
);

    logic unused_latch;
    assign unused_latch = (UNUSED_LATCH != 0);

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ok;
    logic       wb_to_pc;
    alu_dec_t   alu_dec;
    logic       mem_we_c, ir_we_c, pc_we_c, reg_we_c, done_c, illegal_c;

    multicycle_ctrl_cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags_q),
        .cond_ok (cond_ok)
    );

    assign alu_dec  = alu_decode(funct[4:1]);
    assign wb_to_pc = (rd == PC_REG);

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        mem_req    = 1'b0;
        mem_we_c   = 1'b0;
        adr_src    = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        reg_we_c   = 1'b0;
        done_c     = 1'b0;
        illegal_c  = 1'b0;
        alu_src_a  = AluSrcAReg;
        alu_src_b  = AluSrcBReg;
        result_src = ResAluOut;
        alu_ctrl   = AluAdd;
        case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_a  = AluSrcAPc;
                alu_src_b  = AluSrcBFour;
                result_src = ResAluResult;
                ir_we_c    = mem_ready;
                pc_we_c    = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                alu_src_a = AluSrcAPc;
                alu_src_b = AluSrcBFour;
                if (!cond_ok || op == OpIllegal) begin
                    done_c    = 1'b1;
                    illegal_c = (op == OpIllegal);
                    state_d   = StFetch;
                end else begin
                    case (op)
                        OpMem:    state_d = StMemAdr;
                        OpDp:     state_d = funct[5] ? StExecI : StExecR;
                        OpBranch: state_d = StBranch;
                        default:  state_d = StFetch;
                    endcase
                end
            end
            StMemAdr: begin
                alu_src_b = AluSrcBImm;
                state_d   = funct[0] ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResData;
                pc_we_c    = wb_to_pc;
                reg_we_c   = ~wb_to_pc;
                done_c     = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req  = 1'b1;
                adr_src  = 1'b1;
                mem_we_c = 1'b1;
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecR, StExecI: begin
                alu_src_b = (state_q == StExecI) ? AluSrcBImm : AluSrcBReg;
                alu_ctrl  = alu_dec.alu_ctrl;
                state_d   = StAluWb;
                // Logical ops leave C and V untouched.
                if (funct[0]) begin
                    case (alu_dec.flag_w)
                        FlagWAll: flags_d = alu_flags;
                        FlagWNz:  flags_d = {alu_flags[3:2], flags_q[1:0]};
                        default:  flags_d = flags_q;
                    endcase
                end
            end
            StAluWb: begin
                result_src = ResAluOut;
                pc_we_c    = wb_to_pc;
                reg_we_c   = ~wb_to_pc;
                done_c     = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_b  = AluSrcBImm;
                result_src = ResAluResult;
                pc_we_c    = 1'b1;
                done_c     = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // Gate strobes with the raw reset so nothing writes while reset is held.
    assign mem_we     = mem_we_c & rst_n;
    assign ir_we      = ir_we_c & rst_n;
    assign pc_we      = pc_we_c & rst_n;
    assign reg_we     = reg_we_c & rst_n;
    assign instr_done = done_c & rst_n;
    assign illegal    = illegal_c & rst_n;

    assign imm_src = op;
    assign reg_src = {(op == OpMem) & ~funct[0], (op == OpBranch)};
    assign flags   = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected controls are queued per instruction
// and compared (under a don't-care mask) as the FSM steps.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, alu_src_a;
    logic [1:0] alu_src_b, result_src, alu_ctrl, imm_src, reg_src;
    logic [3:0] flags;
    logic       instr_done, illegal;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cond       (cond),
        .op         (op),
        .funct      (funct),
        .rd         (rd),
        .alu_flags  (alu_flags),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_ctrl   (alu_ctrl),
        .imm_src    (imm_src),
        .reg_src    (reg_src),
        .flags      (flags),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, instr_done, illegal,
    //                   alu_src_a, alu_src_b, result_src, alu_ctrl}
    typedef struct {
        string       tag;
        logic        rdy;
        logic [14:0] val;
        logic [14:0] mask;
    } exp_t;

    exp_t sb[$];

    localparam logic [6:0] MA  = 7'b1000000;
    localparam logic [6:0] MB  = 7'b0110000;
    localparam logic [6:0] MRS = 7'b0001100;
    localparam logic [6:0] MCT = 7'b0000011;

    task automatic push(input string tag, input logic rdy, input logic [7:0] strb,
                        input logic adr_known, input logic [6:0] alu, input logic [6:0] amask);
        exp_t e;
        e.tag  = tag;
        e.rdy  = rdy;
        e.val  = {strb, alu};
        e.mask = {2'b11, adr_known, 5'b11111, amask};
        sb.push_back(e);
    endtask

    task automatic p_fetch(input logic rdy);
        push("fetch", rdy, {3'b100, rdy, rdy, 3'b000}, 1'b1, {1'b1, 2'b10, 2'b10, 2'b00}, 7'h7f);
    endtask
    task automatic p_decode(input logic done, input logic ill);
        push("decode", 1'b0, {6'b0, done, ill}, 1'b0, {1'b1, 2'b10, 2'b00, 2'b00}, MA | MB | MCT);
    endtask
    task automatic p_memadr();
        push("memadr", 1'b0, 8'b0, 1'b0, {1'b0, 2'b01, 2'b00, 2'b00}, MA | MB | MCT);
    endtask
    task automatic p_memread(input logic rdy);
        push("memread", rdy, 8'b1010_0000, 1'b1, 7'b0, 7'b0);
    endtask
    task automatic p_memwb(input logic to_pc);
        push("memwb", 1'b0, {4'b0000, to_pc, ~to_pc, 2'b10}, 1'b0, {5'b0, 2'b01, 2'b00} >> 0, MRS);
    endtask
    task automatic p_memwrite(input logic rdy);
        push("memwrite", rdy, {3'b111, 3'b000, rdy, 1'b0}, 1'b1, 7'b0, 7'b0);
    endtask
    task automatic p_exec(input logic imm, input logic [1:0] ctrl);
        push(imm ? "execi" : "execr", 1'b0, 8'b0, 1'b0, {1'b0, imm ? 2'b01 : 2'b00, 2'b00, ctrl},
             MA | MB | MCT);
    endtask
    task automatic p_aluwb(input logic to_pc);
        push("aluwb", 1'b0, {4'b0000, to_pc, ~to_pc, 2'b10}, 1'b0, 7'b0, MRS);
    endtask
    task automatic p_branch();
        push("branch", 1'b0, 8'b0000_1010, 1'b0, {1'b0, 2'b01, 2'b10, 2'b00}, MA | MB | MRS | MCT);
    endtask

    // Each entry covers one clock: drive mem_ready, sample at negedge, then advance.
    task automatic drain();
        exp_t        e;
        logic [14:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.rdy;
            @(negedge clk);
            obs = {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, instr_done, illegal,
                   alu_src_a, alu_src_b, result_src, alu_ctrl};
            checks++;
            assert ((obs & e.mask) === (e.val & e.mask)) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h (mask %h)", e.tag, obs & e.mask,
                       e.val & e.mask, e.mask);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] af);
        cond = c; op = o; funct = f; rd = r; alu_flags = af;
        #1;
        chk("imm_src", {6'b0, imm_src}, {6'b0, o});
        chk("reg_src", {6'b0, reg_src}, {6'b0, (o == 2'b01) && !f[0], o == 2'b10});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_flags", {4'b0, flags}, 8'h00);
        chk("rst_strobes", {2'b0, ir_we, pc_we, reg_we, mem_we, instr_done, illegal}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        mem_ready = 1'b1;
        cond = 4'b1110; op = 2'b00; funct = 6'b0; rd = 4'd0; alu_flags = 4'b0;
        #1;
        do_reset();

        // ADDS r1
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0110);
        p_fetch(1); p_decode(0, 0); p_exec(0, 2'b00); p_aluwb(0); drain();
        chk("adds_flags", {4'b0, flags}, 8'h06);

        // LDR r15, two wait states in fetch and memread
        set_instr(4'b1110, 2'b01, 6'b000001, 4'd15, 4'b0000);
        p_fetch(0); p_fetch(0); p_fetch(1); p_decode(0, 0); p_memadr();
        p_memread(0); p_memread(0); p_memread(1); p_memwb(1); drain();
        chk("ldr_flags", {4'b0, flags}, 8'h06);

        // ADDS to clear Z
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd2, 4'b0011);
        p_fetch(1); p_decode(0, 0); p_exec(0, 2'b00); p_aluwb(0); drain();
        chk("adds2_flags", {4'b0, flags}, 8'h03);

        // BEQ not taken, BNE taken
        set_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
        p_fetch(1); p_decode(1, 0); drain();
        set_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000);
        p_fetch(1); p_decode(0, 0); p_branch(); drain();

        // ANDS: NZ from ALU, C and V held
        set_instr(4'b1110, 2'b00, 6'b000001, 4'd4, 4'b1011);
        p_fetch(1); p_decode(0, 0); p_exec(0, 2'b10); p_aluwb(0); drain();
        chk("ands_flags", {4'b0, flags}, 8'h0b);

        // ORR immediate, S=0, to PC
        set_instr(4'b1110, 2'b00, 6'b111000, 4'd15, 4'b0101);
        p_fetch(1); p_decode(0, 0); p_exec(1, 2'b11); p_aluwb(1); drain();
        chk("orr_flags", {4'b0, flags}, 8'h0b);

        // SUBS immediate under GE (N==V)
        set_instr(4'b1010, 2'b00, 6'b100101, 4'd5, 4'b0100);
        p_fetch(1); p_decode(0, 0); p_exec(1, 2'b01); p_aluwb(0); drain();
        chk("subs_flags", {4'b0, flags}, 8'h04);

        // Undecoded command with S: ADD, flags untouched
        set_instr(4'b1110, 2'b00, 6'b011111, 4'd6, 4'b1111);
        p_fetch(1); p_decode(0, 0); p_exec(0, 2'b00); p_aluwb(0); drain();
        chk("undef_flags", {4'b0, flags}, 8'h04);

        // STR under LT (false), then STR AL with one write wait
        set_instr(4'b1011, 2'b01, 6'b000000, 4'd3, 4'b0000);
        p_fetch(1); p_decode(1, 0); drain();
        set_instr(4'b1110, 2'b01, 6'b000000, 4'd3, 4'b0000);
        p_fetch(1); p_decode(0, 0); p_memadr(); p_memwrite(0); p_memwrite(1); drain();

        do_reset();

        // Illegal op, then STR with cond NV
        set_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
        p_fetch(1); p_decode(1, 1); drain();
        set_instr(4'b1111, 2'b01, 6'b000000, 4'd3, 4'b0000);
        p_fetch(1); p_decode(1, 0); drain();

        // Load nonzero flags, then reset in the middle of a stalled store
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b1100);
        p_fetch(1); p_decode(0, 0); p_exec(0, 2'b00); p_aluwb(0); drain();
        chk("adds3_flags", {4'b0, flags}, 8'h0c);
        set_instr(4'b1110, 2'b01, 6'b000000, 4'd3, 4'b0000);
        p_fetch(1); p_decode(0, 0); p_memadr(); p_memwrite(0); drain();
        mem_ready = 1'b0;
        #1;
        chk("pre_rst_mem_we", {7'b0, mem_we}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_we", {7'b0, mem_we}, 8'h00);
        chk("mid_rst_flags", {4'b0, flags}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd2, 4'b1111);
        p_fetch(0); p_fetch(1); p_decode(0, 0); p_exec(0, 2'b00); p_aluwb(0); drain();
        chk("post_rst_flags", {4'b0, flags}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
